alu_arbiter: RTL

Shares a single ALU instance between two requesters: port 0 is the execute stage, port 1 is a secondary client such as the AMO/address unit. The block performs round-robin arbitration with valid/ready handshakes, drives the ALU inputs combinationally from the granted request, and registers the ALU result into a one-entry response slot with backpressure. It sits between the requesters and the ALU, and owns the ALU's control packet and operand inputs.

---
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter.sv | 51 +++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: ALU control type plus the request, ALU and response signals of the arbiter
package DEF;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_SLL = 4'd2;
   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_width;
   } alu_control_packet_t;
endpackage

interface alu_arbiter_if #(parameter int TAG_W = 4);
   import DEF::*;
   logic                req0_valid, req0_ready;
   alu_control_packet_t req0_ctrl;
   logic [63:0]         req0_op1, req0_op2;
   logic [TAG_W-1:0]    req0_tag;
   logic                req1_valid, req1_ready;
   alu_control_packet_t req1_ctrl;
   logic [63:0]         req1_op1, req1_op2;
   logic [TAG_W-1:0]    req1_tag;
   alu_control_packet_t alu_ctrl;
   logic [63:0]         alu_op1, alu_op2, alu_result;
   logic                rsp_valid, rsp_ready, rsp_id;
   logic [TAG_W-1:0]    rsp_tag;
   logic [63:0]         rsp_data;
   modport slave (
      input  req0_valid, req0_ctrl, req0_op1, req0_op2, req0_tag,
      input  req1_valid, req1_ctrl, req1_op1, req1_op2, req1_tag,
      input  alu_result, rsp_ready,
      output req0_ready, req1_ready, alu_ctrl, alu_op1, alu_op2,
      output rsp_valid, rsp_id, rsp_tag, rsp_data
   );
   modport master (
      output req0_valid, req0_ctrl, req0_op1, req0_op2, req0_tag,
      output req1_valid, req1_ctrl, req1_op1, req1_op2, req1_tag,
      output alu_result, rsp_ready,
      input  req0_ready, req1_ready, alu_ctrl, alu_op1, alu_op2,
      input  rsp_valid, rsp_id, rsp_tag, rsp_data
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with a registered response slot
module alu_arbiter #(parameter int TAG_W = 4) (
   input logic clk,
   input logic rst,
   alu_arbiter_if.slave bus
);
   logic             last_grant_q, last_grant_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic [63:0]      rsp_data_q, rsp_data_d;
   logic             slot_free, grant0, grant1, issue0, issue1;
   // grant, ALU drive, ready and next response-slot state
   always_comb begin
      slot_free      = !rsp_valid_q || bus.rsp_ready;
      grant0         = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1         = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
      bus.req0_ready = !rst && slot_free && grant0;
      bus.req1_ready = !rst && slot_free && grant1;
      bus.alu_ctrl   = grant0 ? bus.req0_ctrl : grant1 ? bus.req1_ctrl : '0;
      bus.alu_op1    = grant0 ? bus.req0_op1 : grant1 ? bus.req1_op1 : '0;
      bus.alu_op2    = grant0 ? bus.req0_op2 : grant1 ? bus.req1_op2 : '0;
      issue0         = bus.req0_valid && bus.req0_ready;
      issue1         = bus.req1_valid && bus.req1_ready;
      last_grant_d   = issue1 ? 1'b1 : issue0 ? 1'b0 : last_grant_q;
      rsp_valid_d    = (issue0 || issue1) ? 1'b1 : bus.rsp_ready ? 1'b0 : rsp_valid_q;
      rsp_id_d       = (issue0 || issue1) ? issue1 : rsp_id_q;
      rsp_tag_d      = issue1 ? bus.req1_tag : issue0 ? bus.req0_tag : rsp_tag_q;
      rsp_data_d     = (issue0 || issue1) ? bus.alu_result : rsp_data_q;
   end
   // state registers; reset leaves last_grant at 1 so port 0 wins the first contest
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_tag_q    <= '0;
         rsp_data_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_data_q   <= rsp_data_d;
      end
   end
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_tag   = rsp_tag_q;
   assign bus.rsp_data  = rsp_data_q;
endmodule
